// File: rtl/dmem_responder_pkg.sv
// dmem_responder shared defs: byte-lane select codes, fault codes,
// default depth, fault record and store-select legality helper.
package dmem_responder_pkg;

  localparam int DmemDepthLog2 = 12;

  localparam logic [3:0] SEL_BYTE0 = 4'b0001;
  localparam logic [3:0] SEL_BYTE1 = 4'b0010;
  localparam logic [3:0] SEL_BYTE2 = 4'b0100;
  localparam logic [3:0] SEL_BYTE3 = 4'b1000;
  localparam logic [3:0] SEL_HALF0 = 4'b0011;
  localparam logic [3:0] SEL_HALF1 = 4'b1100;
  localparam logic [3:0] SEL_WORD  = 4'b1111;

  typedef enum logic [1:0] {
    FaultNone     = 2'b00,
    FaultMisalign = 2'b01,
    FaultRange    = 2'b10
  } fault_e;

  typedef struct packed {
    logic        flag;
    fault_e      kind;
    logic [31:0] addr;
  } fault_t;

  function automatic logic sel_legal(
    input logic [3:0] sel
  );
    logic ok;
    unique case (sel)
      SEL_BYTE0, SEL_BYTE1,
      SEL_BYTE2, SEL_BYTE3,
      SEL_HALF0, SEL_HALF1,
      SEL_WORD: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data RAM bus: access request, combinational load data,
// sticky fault record and its clear. master = MEM stage, slave = dmem.
interface dmem_responder_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        fault_o;
  logic [1:0]  fault_type_o;
  logic [31:0] fault_addr_o;
  logic        fault_clr_i;

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i,
    output mem_addr_i, mem_data_i,
    output fault_clr_i,
    input  mem_data_o,
    input  fault_o, fault_type_o, fault_addr_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i,
    input  mem_addr_i, mem_data_i,
    input  fault_clr_i,
    output mem_data_o,
    output fault_o, fault_type_o, fault_addr_o
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage: async read (raddr->rdata), byte-lane sync write
// (we/waddr/wsel/wdata on clk). No reset; maps to distributed RAM.
module dmem_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [3:0]            wsel,
  input  logic [31:0]           wdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wsel[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data memory responder: zero-latency loads, one-entry posted store
// buffer with forwarding, sticky fault record. Ports: clk, rst, bus.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DmemDepthLog2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int HI = DEPTH_LOG2 + 2;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  sel_ok;
  logic                  st_ok;
  logic                  range_err;
  logic                  align_err;
  fault_e                kind;

  logic                  wb_valid;
  logic [DEPTH_LOG2-1:0] wb_idx;
  logic [3:0]            wb_sel;
  logic [31:0]           wb_data;

  logic [31:0]           arr_rdata;
  logic [31:0]           rd;
  fault_t                flt;

  assign idx      = bus.mem_addr_i[HI-1:2];
  assign in_range = bus.mem_addr_i[31:HI] == BASE_ADDR[31:HI];
  assign sel_ok   = sel_legal(bus.mem_sel_i);

  assign st_ok = bus.mem_ce_i & bus.mem_we_i
               & in_range & sel_ok;

  // Range faults cover loads and stores; a bad lane
  // mask only counts when the range is fine, so the
  // two are exclusive and range wins.
  assign range_err = bus.mem_ce_i & ~in_range;
  assign align_err = bus.mem_ce_i & bus.mem_we_i
                   & in_range & ~sel_ok;

  always_comb begin
    kind = FaultNone;
    unique case (1'b1)
      range_err: kind = FaultRange;
      align_err: kind = FaultMisalign;
      default:   kind = FaultNone;
    endcase
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .raddr (idx),
    .rdata (arr_rdata),
    .we    (wb_valid),
    .waddr (wb_idx),
    .wsel  (wb_sel),
    .wdata (wb_data)
  );

  // The buffered store is newer than the array word,
  // so its lanes override on a matching index.
  always_comb begin
    rd = arr_rdata;
    for (int b = 0; b < 4; b++) begin
      if (wb_valid && wb_idx == idx && wb_sel[b]) begin
        rd[8*b +: 8] = wb_data[8*b +: 8];
      end
    end
    if (!rst || !bus.mem_ce_i || !in_range) begin
      rd = '0;
    end
  end

  assign bus.mem_data_o = rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_sel   <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= st_ok;
      if (st_ok) begin
        wb_idx  <= idx;
        wb_sel  <= bus.mem_sel_i;
        wb_data <= bus.mem_data_i;
      end
    end
  end

  // A new fault may overwrite only an empty record or
  // one being cleared this cycle (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt <= '{1'b0, FaultNone, 32'h0};
    end else if (kind != FaultNone
                 && (!flt.flag || bus.fault_clr_i)) begin
      flt <= '{1'b1, kind, bus.mem_addr_i};
    end else if (bus.fault_clr_i) begin
      flt <= '{1'b0, FaultNone, 32'h0};
    end
  end

  assign bus.fault_o      = flt.flag;
  assign bus.fault_type_o = flt.kind;
  assign bus.fault_addr_o = flt.addr;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus
// random traffic against a word-level memory and fault model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_LOG2(12),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        f;
    logic [1:0]  t;
    logic [31:0] a;
    int          n;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // vis: what a load sees; every legal store lands at once.
  // undo_*: last store, discarded if reset hits before it lands.
  logic [31:0] vis [4096];
  bit          undo_v = 1'b0;
  int          undo_i = 0;
  logic [31:0] undo_w = 32'h0;
  logic        mf = 1'b0;
  logic [1:0]  mt = 2'b00;
  logic [31:0] ma = 32'h0;

  localparam int NP = 19;
  logic [31:0] pool [NP] = '{
    32'h100, 32'h104, 32'h108, 32'h10C,
    32'h110, 32'h114, 32'h118, 32'h11C,
    32'h120, 32'h124, 32'h128, 32'h12C,
    32'h130, 32'h134, 32'h138, 32'h13C,
    32'h200, 32'h300, 32'h400
  };
  logic [3:0] lsel [7] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0011, 4'b1100, 4'b1111
  };

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv, input int n);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h",
               nm, n, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("rdata", bus.mem_data_o, e.d, e.n);
      chk("fault", {31'b0, bus.fault_o}, {31'b0, e.f}, e.n);
      chk("ftype", {30'b0, bus.fault_type_o}, {30'b0, e.t}, e.n);
      chk("faddr", bus.fault_addr_o, e.a, e.n);
    end
  end

  task automatic drive(
    input logic        ce,
    input logic        we,
    input logic [3:0]  sel,
    input logic [31:0] addr,
    input logic [31:0] data,
    input logic        clr,
    input bit          use_exp = 1'b0,
    input logic [31:0] exp_d = 32'h0
  );
    exp_t       e;
    int         i;
    logic       in_rng;
    logic       legal;
    logic       det;
    logic [1:0] ty;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_ce_i    = ce;
    bus.mem_we_i    = we;
    bus.mem_sel_i   = sel;
    bus.mem_addr_i  = addr;
    bus.mem_data_i  = data;
    bus.fault_clr_i = clr;
    cyc++;
    in_rng = (addr[31:14] == 18'd0);
    i = int'(addr[13:2]);
    e.d = (ce && in_rng) ? vis[i] : 32'h0;
    if (use_exp) e.d = exp_d;
    e.f = mf;
    e.t = mt;
    e.a = ma;
    e.n = cyc;
    sbq.push_back(e);
    legal = sel inside {4'b0001, 4'b0010, 4'b0100,
                        4'b1000, 4'b0011, 4'b1100,
                        4'b1111};
    undo_v = 1'b0;
    if (ce && we && in_rng && legal) begin
      undo_v = 1'b1;
      undo_i = i;
      undo_w = vis[i];
      for (int b = 0; b < 4; b++)
        if (sel[b]) vis[i][8*b +: 8] = data[8*b +: 8];
    end
    det = 1'b0;
    ty  = 2'b00;
    if (ce && !in_rng) begin
      det = 1'b1;
      ty  = 2'b10;
    end else if (ce && we && !legal) begin
      det = 1'b1;
      ty  = 2'b01;
    end
    if (det && (!mf || clr)) begin
      mf = 1'b1;
      mt = ty;
      ma = addr;
    end else if (clr) begin
      mf = 1'b0;
      mt = 2'b00;
      ma = 32'h0;
    end
  endtask

  task automatic do_reset(input logic [31:0] addr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_ce_i    = 1'b1;
    bus.mem_we_i    = 1'b0;
    bus.mem_sel_i   = 4'b1111;
    bus.mem_addr_i  = addr;
    bus.fault_clr_i = 1'b0;
    cyc++;
    if (undo_v) vis[undo_i] = undo_w;
    undo_v = 1'b0;
    mf = 1'b0;
    mt = 2'b00;
    ma = 32'h0;
    e = '{32'h0, 1'b0, 2'b00, 32'h0, cyc};
    sbq.push_back(e);
  endtask

  task automatic idle(input logic clr = 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, clr);
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    logic [31:0] d;
    logic        c;
    logic [3:0]  s;
    bus.mem_ce_i    = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_sel_i   = 4'b0000;
    bus.mem_addr_i  = 32'h0;
    bus.mem_data_i  = 32'h0;
    bus.fault_clr_i = 1'b0;
    do_reset(32'h100);
    for (int k = 0; k < NP; k++)
      drive(1'b1, 1'b1, 4'b1111, pool[k], $urandom, 1'b0);

    // store then forwarded load, then load from array
    drive(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0,
          1'b1, 32'hDEADBEEF);
    idle();
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0,
          1'b1, 32'hDEADBEEF);

    // byte merge onto a pending word store
    drive(1'b1, 1'b1, 4'hF, 32'h200, 32'h11223344, 1'b0);
    drive(1'b1, 1'b1, 4'b0010, 32'h201, 32'hAAAAAAAA, 1'b0);
    drive(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0,
          1'b1, 32'h1122AA44);
    idle();
    drive(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0,
          1'b1, 32'h1122AA44);

    // back-to-back halfword stores to one word
    drive(1'b1, 1'b1, 4'b0011, 32'h300, 32'h55665566, 1'b0);
    drive(1'b1, 1'b1, 4'b1100, 32'h302, 32'h77887788, 1'b0);
    drive(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0,
          1'b1, 32'h77885566);

    // misaligned, sticky, then clear-with-new-fault
    drive(1'b1, 1'b1, 4'b0000, 32'h303, 32'h12341234, 1'b0);
    drive(1'b1, 1'b0, 4'hF, 32'h0010_0000, 32'h0, 1'b0,
          1'b1, 32'h0);
    drive(1'b1, 1'b0, 4'hF, 32'h0010_0000, 32'h0, 1'b1,
          1'b1, 32'h0);
    drive(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0,
          1'b1, 32'h77885566);
    idle(1'b1);
    idle();

    // reset discards the pending store
    drive(1'b1, 1'b1, 4'hF, 32'h400, 32'h12345678, 1'b0);
    idle();
    drive(1'b1, 1'b1, 4'hF, 32'h400, 32'hCAFEF00D, 1'b0);
    do_reset(32'h400);
    drive(1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b0,
          1'b1, 32'h12345678);

    // idle bus with bad sel: no fault, pending commits
    drive(1'b1, 1'b1, 4'hF, 32'h104, 32'h0BADF00D, 1'b0);
    drive(1'b0, 1'b1, 4'b0000, 32'h303, 32'hFFFFFFFF, 1'b0);
    drive(1'b1, 1'b0, 4'hF, 32'h104, 32'h0, 1'b0,
          1'b1, 32'h0BADF00D);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      a = pool[$urandom_range(NP-1)] | ($urandom & 32'h3);
      d = $urandom;
      c = ($urandom_range(7) == 0);
      if (r < 1) begin
        do_reset(a);
      end else if (r < 35) begin
        drive(1'b1, 1'b0, 4'($urandom), a, d, c);
      end else if (r < 65) begin
        s = lsel[$urandom_range(6)];
        drive(1'b1, 1'b1, s, a, d, c);
      end else if (r < 75) begin
        s = 4'($urandom);
        while (s inside {4'b0001, 4'b0010, 4'b0100,
                         4'b1000, 4'b0011, 4'b1100,
                         4'b1111})
          s = 4'($urandom);
        drive(1'b1, 1'b1, s, a, d, c);
      end else if (r < 82) begin
        drive(1'b1, 1'($urandom), 4'($urandom),
              $urandom | 32'h0000_4000, d, c);
      end else begin
        drive(1'b0, 1'($urandom), 4'($urandom),
              $urandom, d, c);
      end
    end

    idle();
    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
